pos_edge_delay_meter: RTL and testbench
=======================================

# pos_edge_delay_meter

- Measures, in `clk` cycles, the rising-edge delay between a reference input `sigRef` and a delayed copy `sigDly`, plus the `sigRef` period.
- It is the measurement end of the phase-delay path: the delay stage imposes a programmed rising-edge delay, and this block reads back the delay actually produced.
- Results feed the delay-table readback and closed-loop trim logic.

## Interface
- `WAIT_CNT_SIZE`, 11, width of delay counter and `delayCnt` (matches the delay stage's wait count).
- `PERIOD_CNT_SIZE`, 16, width of period counter and `periodCnt`.
- `clk  in  1  system clock; every register updates on its rising edge.`
- `rst  in  1  reset, synchronous, active-high.`
- `sigRef  in  1  reference signal, asynchronous to clk.`
- `sigDly  in  1  delayed signal, asynchronous to clk.`
- `delayCnt  out  WAIT_CNT_SIZE  last measured ref-to-dly delay in clk cycles; held between measurements.`
- `delayValid  out  1  one-cycle pulse when delayCnt/delayOvf update.`
- `delayOvf  out  1  set with delayValid when the measurement saturated; held until next delayValid.`
- `delayMissed  out  1  sticky; set when a new ref edge arrives before the dly edge; cleared by rst only.`
- `periodCnt  out  PERIOD_CNT_SIZE  last ref rise-to-rise period in clk cycles; held.`
- `periodValid  out  1  one-cycle pulse when periodCnt updates.`

## Operation
- Each input passes through a 2-FF synchronizer, then a third "last" register. Detected rise = sync2 & ~last.
  - Both inputs see identical latency, so the difference cancels.
- Delay FSM, states WAIT_REF and TIMING; `dlyTimer` is WAIT_CNT_SIZE bits. Define MAXD = 2^WAIT_CNT_SIZE-1.
- WAIT_REF:
  - refRise alone: dlyTimer<=0, go TIMING.
  - refRise and dlyRise in the same cycle: delayCnt<=0, delayValid, delayOvf<=0, stay WAIT_REF.
  - dlyRise alone is ignored.
- TIMING, first matching rule applies:
  - dlyRise (with or without refRise): delayCnt<=dlyTimer+1, delayValid, delayOvf<=0.
    - If refRise is also present, this dly edge belongs to the old ref. Then dlyTimer<=0 and stay TIMING; otherwise go WAIT_REF.
  - refRise without dlyRise: delayMissed<=1, dlyTimer<=0, stay TIMING. No delayValid.
  - dlyTimer==MAXD: delayCnt<=MAXD, delayOvf<=1, delayValid, go WAIT_REF.
  - Otherwise dlyTimer<=dlyTimer+1.
- Result: a dly rise detected k cycles after the ref rise reports delayCnt=k, for 0<=k<=MAXD. If k>MAXD, overflow reports at cycle MAXD+1.
- Period path, `perTimer` is PERIOD_CNT_SIZE bits, MAXP = 2^PERIOD_CNT_SIZE-1. `perArmed` is cleared by reset.
  - Every cycle without refRise: perTimer increments, saturating at MAXP.
  - On refRise with perArmed=1: periodCnt<=min(perTimer+1, MAXP) and periodValid pulses.
  - On every refRise: perTimer<=0 and perArmed<=1.
  - First ref rise after reset produces no periodValid.
- Reset (any cycle, including mid-measurement):
  - All outputs go to 0: delayCnt, delayValid, delayOvf, delayMissed, periodCnt, periodValid.
  - State returns to WAIT_REF; timers, synchronizers, last registers and perArmed go to 0.
  - A level already high on an input when rst falls is not a rise.

## Timing
- Input change sampled at clk edge n: detected rise is active in the cycle after edge n+2.
- delayValid/periodValid are registered and high in the cycle after the detecting cycle. Input edge to valid is therefore 4 clk edges.
- Valid pulses are exactly one cycle; no ready/ack handshake. Consumers capture on the pulse.
- delayCnt/periodCnt change only together with their valid pulse.
- Input pulses narrower than 1 clk period may be missed. This is by design; not an error.

## Test plan
- Delay 0 and 1:
  - sigRef and sigDly rise on the same sample -> one delayValid, delayCnt=0, delayOvf=0.
  - sigDly one cycle later -> delayCnt=1.
- Nominal delay: sigRef square wave, period 1000 clk; sigDly = sigRef delayed 37 clk.
  - -> delayValid every period with delayCnt=37.
  - -> periodValid from the second ref edge on with periodCnt=1000.
  - -> delayMissed stays 0.
- Saturation, default widths: sigDly never rises.
  - -> delayValid 2048 cycles after the detected ref rise, with delayCnt=2047 and delayOvf=1.
  - -> The next valid measurement (delay 10) reports delayOvf=0.
- Missed edge: ref rises at t and t+50, dly at t+70 -> delayMissed=1, delayCnt=20, a single delayValid.
- Simultaneous edges: in TIMING, refRise and dlyRise coincide at 30 cycles, then dly rises 5 later.
  - -> delayCnt=30 then delayCnt=5.
  - -> delayMissed stays 0.
- Reset mid-measurement: rst for 1 cycle while TIMING -> all outputs 0 next cycle.
  - -> The trailing dly edge produces no delayValid.
  - -> The first ref after reset produces no periodValid.

Source files
------------

// File: rtl/pos_edge_delay_meter.sv
// pos_edge_delay_meter
// Measures the rising-edge delay from sigRef to sigDly and the sigRef
// rise-to-rise period, both in clk cycles. Both inputs are asynchronous
// and share an identical synchronizer path, so that latency cancels out of
// the delay measurement.
module pos_edge_delay_meter #(
  parameter int WAIT_CNT_SIZE   = 11,
  parameter int PERIOD_CNT_SIZE = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sigRef,
  input  logic                       sigDly,
  output logic [WAIT_CNT_SIZE-1:0]   delayCnt,
  output logic                       delayValid,
  output logic                       delayOvf,
  output logic                       delayMissed,
  output logic [PERIOD_CNT_SIZE-1:0] periodCnt,
  output logic                       periodValid
);

  localparam logic [WAIT_CNT_SIZE-1:0]   MAXD = '1;
  localparam logic [PERIOD_CNT_SIZE-1:0] MAXP = '1;

  localparam logic [0:0] S_WAIT_REF = 1'b0;
  localparam logic [0:0] S_TIMING   = 1'b1;

  // Bit 0 carries sigRef, bit 1 carries sigDly through identical stages.
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_last;
  logic [1:0] r_rise;
  // Counts clk edges since reset until the last-register holds a real
  // post-reset sample; rises are masked until then so that a level already
  // high when rst falls is not mistaken for an edge.
  logic [1:0] r_fill;

  logic       w_ref_rise;
  logic       w_dly_rise;
  logic       w_chain_ready;

  logic [0:0]               r_state;
  logic [WAIT_CNT_SIZE-1:0] r_dly_timer;

  logic [PERIOD_CNT_SIZE-1:0] r_per_timer;
  logic                       r_per_armed;

  assign w_chain_ready = (r_fill == 2'd3);
  assign w_ref_rise    = r_rise[0];
  assign w_dly_rise    = r_rise[1];

  // Synchronize both inputs and register the detected rising edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_last  <= '0;
      r_rise  <= '0;
      r_fill  <= '0;
    end else begin
      r_sync1 <= {sigDly, sigRef};
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
      r_rise  <= r_sync2 & ~r_last & {2{w_chain_ready}};
      if (!w_chain_ready) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

  // Delay FSM: time from a ref rise to the following dly rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_WAIT_REF;
      r_dly_timer <= '0;
      delayCnt    <= '0;
      delayValid  <= 1'b0;
      delayOvf    <= 1'b0;
      delayMissed <= 1'b0;
    end else begin
      delayValid <= 1'b0;
      case (r_state)
        S_WAIT_REF: begin
          if (w_ref_rise && w_dly_rise) begin
            delayCnt   <= '0;
            delayValid <= 1'b1;
            delayOvf   <= 1'b0;
          end else if (w_ref_rise) begin
            r_dly_timer <= '0;
            r_state     <= S_TIMING;
          end
        end
        S_TIMING: begin
          if (w_dly_rise) begin
            delayValid <= 1'b1;
            // A dly edge landing exactly one cycle past the counter range
            // is reported saturated rather than wrapping to zero.
            if (r_dly_timer == MAXD) begin
              delayCnt <= MAXD;
              delayOvf <= 1'b1;
            end else begin
              delayCnt <= r_dly_timer + 1'b1;
              delayOvf <= 1'b0;
            end
            // A coincident ref edge starts the next measurement at once.
            if (w_ref_rise) begin
              r_dly_timer <= '0;
            end else begin
              r_state <= S_WAIT_REF;
            end
          end else if (w_ref_rise) begin
            delayMissed <= 1'b1;
            r_dly_timer <= '0;
          end else if (r_dly_timer == MAXD) begin
            delayCnt   <= MAXD;
            delayOvf   <= 1'b1;
            delayValid <= 1'b1;
            r_state    <= S_WAIT_REF;
          end else begin
            r_dly_timer <= r_dly_timer + 1'b1;
          end
        end
        default: begin
          r_state <= S_WAIT_REF;
        end
      endcase
    end
  end

  // Period path: saturating rise-to-rise timer, first edge after reset only arms it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_per_timer <= '0;
      r_per_armed <= 1'b0;
      periodCnt   <= '0;
      periodValid <= 1'b0;
    end else begin
      periodValid <= 1'b0;
      if (w_ref_rise) begin
        if (r_per_armed) begin
          periodValid <= 1'b1;
          periodCnt   <= (r_per_timer == MAXP) ? MAXP : (r_per_timer + 1'b1);
        end
        r_per_timer <= '0;
        r_per_armed <= 1'b1;
      end else if (r_per_timer != MAXP) begin
        r_per_timer <= r_per_timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pos_edge_delay_meter.sv
// Self-checking bench for pos_edge_delay_meter: a per-cycle input schedule is
// fed both to the DUT and to an edge-time reference model; reported results
// are compared as ordered sequences.
module tb_pos_edge_delay_meter;

  localparam int W    = 11;
  localparam int P    = 16;
  localparam int MAXD = (1 << W) - 1;
  localparam int MAXP = (1 << P) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sigRef = 1'b0;
  logic           sigDly = 1'b0;
  logic [W-1:0]   delayCnt;
  logic           delayValid;
  logic           delayOvf;
  logic           delayMissed;
  logic [P-1:0]   periodCnt;
  logic           periodValid;

  int total = 0;
  int bad   = 0;
  int hold_viol = 0;

  logic [W:0]   exp_d[$];
  logic [W:0]   got_d[$];
  logic [P-1:0] exp_p[$];
  logic [P-1:0] got_p[$];

  // reference model state (edge times in input-cycle units)
  int m_t = 0;
  int m_pend_t = 0;
  int m_last_ref = 0;
  bit m_pend = 0;
  bit m_armed = 0;
  bit m_missed = 0;
  bit m_pr = 0;
  bit m_pd = 0;

  bit           prev_rst = 1'b1;
  logic [W-1:0] prev_dcnt = '0;
  logic [P-1:0] prev_pcnt = '0;

  pos_edge_delay_meter #(.WAIT_CNT_SIZE(W), .PERIOD_CNT_SIZE(P)) dut (
    .clk(clk), .rst(rst), .sigRef(sigRef), .sigDly(sigDly),
    .delayCnt(delayCnt), .delayValid(delayValid), .delayOvf(delayOvf),
    .delayMissed(delayMissed), .periodCnt(periodCnt), .periodValid(periodValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // capture result pulses and watch that held values never change silently
  always @(negedge clk) begin
    if (!rst) begin
      if (delayValid) got_d.push_back({delayOvf, delayCnt});
      if (periodValid) got_p.push_back(periodCnt);
      if (!prev_rst && !delayValid && delayCnt !== prev_dcnt) hold_viol++;
      if (!prev_rst && !periodValid && periodCnt !== prev_pcnt) hold_viol++;
    end
    prev_rst  = rst;
    prev_dcnt = delayCnt;
    prev_pcnt = periodCnt;
  end

  task automatic push_delay(input int k);
    logic [W:0] e;
    if (k > MAXD) e = {1'b1, W'(MAXD)};
    else          e = {1'b0, W'(k)};
    exp_d.push_back(e);
  endtask

  // one input cycle of the reference model
  task automatic model_step(input logic r, input logic d);
    bit rr, dr;
    int k;
    m_t++;
    rr = r && !m_pr;
    dr = d && !m_pd;
    m_pr = r;
    m_pd = d;
    if (!m_pend) begin
      if (rr && dr) push_delay(0);
      else if (rr) begin m_pend = 1; m_pend_t = m_t; end
    end else begin
      k = m_t - m_pend_t;
      if (dr) begin
        push_delay(k);
        if (rr) m_pend_t = m_t; else m_pend = 0;
      end else if (rr) begin
        m_missed = 1;
        m_pend_t = m_t;
      end else if (k == MAXD + 1) begin
        push_delay(k);
        m_pend = 0;
      end
    end
    if (rr) begin
      if (m_armed) exp_p.push_back(P'((m_t - m_last_ref) > MAXP ? MAXP : (m_t - m_last_ref)));
      m_armed = 1;
      m_last_ref = m_t;
    end
  endtask

  task automatic step(input logic r, input logic d);
    @(posedge clk);
    #1;
    sigRef = r;
    sigDly = d;
    model_step(r, d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_pend = 0; m_armed = 0; m_missed = 0;
    m_pr = sigRef; m_pd = sigDly;
    chk("rst_dcnt", 32'(delayCnt), 0);
    chk("rst_dval", 32'(delayValid), 0);
    chk("rst_dovf", 32'(delayOvf), 0);
    chk("rst_miss", 32'(delayMissed), 0);
    chk("rst_pcnt", 32'(periodCnt), 0);
    chk("rst_pval", 32'(periodValid), 0);
  endtask

  // drop inputs, let the pipeline drain, then compare result sequences
  task automatic settle(input string tag);
    int n;
    repeat (8) step(1'b0, 1'b0);
    chk($sformatf("%s_ndly", tag), 32'(got_d.size()), 32'(exp_d.size()));
    chk($sformatf("%s_nper", tag), 32'(got_p.size()), 32'(exp_p.size()));
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_dly%0d", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
    n = (got_p.size() < exp_p.size()) ? got_p.size() : exp_p.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_per%0d", tag, i), 32'(got_p[i]), 32'(exp_p[i]));
    chk($sformatf("%s_missed", tag), 32'(delayMissed), 32'(m_missed));
    $display("phase %s: %0d delay and %0d period results", tag, exp_d.size(), exp_p.size());
    got_d.delete(); exp_d.delete(); got_p.delete(); exp_p.delete();
  endtask

  initial begin
    int per, dl;
    logic r, d;

    repeat (3) @(posedge clk);
    do_reset();
    repeat (5) step(1'b0, 1'b0);

    // delay 0 with latency check, then delay 1
    step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    chk("lat_early", 32'(delayValid), 0);
    step(1'b1, 1'b1);
    chk("lat_valid", 32'(delayValid), 1);
    chk("lat_cnt0", 32'(delayCnt), 0);
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    settle("d01");

    // nominal: period 1000, delay 37
    for (int o = 0; o < 3100; o++)
      step(1'b1 && ((o % 1000) < 500), (o >= 37) && (((o - 37) % 1000) < 500));
    settle("nominal");

    // random square waves
    for (int run = 0; run < 5; run++) begin
      per = $urandom_range(300, 40);
      dl  = $urandom_range(per - 2, 0);
      for (int o = 0; o < 3 * per + dl + 2; o++)
        step((o % per) < (per / 2), (o >= dl) && (((o - dl) % per) < (per / 2)));
      settle($sformatf("sq%0d", run));
    end

    // saturation, then a normal delay of 10
    for (int o = 0; o < 2200; o++)
      step((o < 2110) || (o >= 2150), o >= 2160);
    settle("sat");

    // coincident ref/dly edges in TIMING: 30 then 5
    for (int o = 0; o < 60; o++)
      step((o < 10) || (o >= 30 && o < 40), (o >= 30 && o < 33) || (o >= 35 && o < 45));
    settle("simul");

    // random toggling of both inputs
    r = 1'b0; d = 1'b0;
    for (int o = 0; o < 2000; o++) begin
      if ($urandom_range(7, 0) == 0) r = ~r;
      if ($urandom_range(7, 0) == 0) d = ~d;
      step(r, d);
    end
    settle("rand");

    // missed edge: ref at 0 and 50, dly at 70
    do_reset();
    repeat (5) step(1'b0, 1'b0);
    for (int o = 0; o < 80; o++)
      step((o < 20) || (o >= 50), (o >= 70));
    chk("missed_set", 32'(delayMissed), 1);
    settle("missed");

    // reset while TIMING, with ref still high at release
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    do_reset();
    repeat (6) step(1'b1, 1'b0);
    repeat (6) step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    repeat (13) step(1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b1);
    settle("midrst");

    chk("hold", 32'(hold_viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
